// File: rtl/booth_digit_decoder.sv
// Sequential radix-8 Booth digit decoder: rebuilds the unsigned operand from a
// vector of signed Booth digits by Horner accumulation, MSB digit first.
`timescale 1ns/1ps

module booth_digit_decoder #(
  parameter int num_par_prod = 9,
  parameter int input_nbit   = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [num_par_prod-1:0][4:0] d,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [input_nbit-1:0]        y,
  output logic                         err_onehot,
  output logic                         err_range
);

  localparam int ACC_W = input_nbit + 3;
  localparam int CNT_W = (num_par_prod > 1) ? $clog2(num_par_prod) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef struct packed {
    logic signed [3:0] value;
    logic              bad;
  } digit_t;

  // A digit with several magnitude bits set is flagged and contributes zero.
  function automatic digit_t decode_digit(input logic [4:0] dig);
    digit_t     r;
    logic [2:0] mag;
    r.bad = 1'b0;
    mag   = 3'd0;
    case (dig[3:0])
      4'b0000: mag = 3'd0;
      4'b0001: mag = 3'd1;
      4'b0010: mag = 3'd2;
      4'b0100: mag = 3'd3;
      4'b1000: mag = 3'd4;
      default: r.bad = 1'b1;
    endcase
    r.value = dig[4] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    return r;
  endfunction

  state_e                         state_q, state_d;
  logic [num_par_prod-1:0][4:0]   digits_q, digits_d;
  logic signed [ACC_W-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           onehot_q, onehot_d;
  logic                           range_q, range_d;
  logic [input_nbit-1:0]          y_q, y_d;

  digit_t                         cur;
  logic signed [ACC_W-1:0]        acc_step;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d  = state_q;
    digits_d = digits_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    onehot_d = onehot_q;
    range_d  = range_q;
    y_d      = y_q;

    cur      = decode_digit(digits_q[cnt_q]);
    acc_step = (acc_q <<< 3) + signed'({{(ACC_W-4){cur.value[3]}}, cur.value});

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          digits_d = d;
          acc_d    = '0;
          cnt_d    = CNT_W'(num_par_prod - 1);
          onehot_d = 1'b0;
          range_d  = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d = acc_step;
        if (cur.bad) onehot_d = 1'b1;
        if (cnt_q == '0) begin
          // Result and range flag are captured once so they hold steady in DONE.
          y_d     = acc_step[input_nbit-1:0];
          range_d = acc_step[ACC_W-1] | (|acc_step[ACC_W-2:input_nbit]);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      onehot_q <= 1'b0;
      range_q  <= 1'b0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      range_q  <= range_d;
      y_q      <= y_d;
    end
  end

  // NOTE: the digit store is not reset; it is always rewritten before it is read.
  always_ff @(posedge clk) begin
    digits_q <= digits_d;
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign y          = y_q;
  assign err_onehot = onehot_q;
  assign err_range  = range_q;

endmodule

// File: tb/tb_booth_digit_decoder.sv
// Self-checking bench for booth_digit_decoder: arithmetic reference model plus
// directed vectors with hand-computed results.
`timescale 1ns/1ps

module tb_booth_digit_decoder;

  localparam int NP = 9;
  localparam int NB = 24;

  typedef logic [NP-1:0][4:0] vec_t;

  localparam logic [4:0] P1 = 5'b00001;
  localparam logic [4:0] P2 = 5'b00010;
  localparam logic [4:0] P3 = 5'b00100;
  localparam logic [4:0] P4 = 5'b01000;
  localparam logic [4:0] N1 = 5'b10001;
  localparam logic [4:0] N2 = 5'b10010;
  localparam logic [4:0] N4 = 5'b11000;
  localparam logic [4:0] NZ = 5'b10000;
  localparam logic [4:0] BAD = 5'b00110;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  vec_t          d = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [NB-1:0] y;
  logic          err_onehot;
  logic          err_range;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  booth_digit_decoder #(.num_par_prod(NP), .input_nbit(NB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .d(d),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .err_onehot(err_onehot), .err_range(err_range)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Operand value = sum of digit_i * 8^i, reduced to a 27-bit signed accumulator.
  function automatic void model(input vec_t v, output logic [NB-1:0] my,
                                output logic moh, output logic mrg);
    longint      acc;
    longint      ws;
    longint      mag;
    logic [3:0]  m;
    logic [26:0] w;
    acc = 0;
    moh = 1'b0;
    for (int i = NP - 1; i >= 0; i--) begin
      m = v[i][3:0];
      if ($countones(m) > 1) begin
        moh = 1'b1;
        mag = 0;
      end else if (m[3]) mag = 4;
      else if (m[2]) mag = 3;
      else if (m[1]) mag = 2;
      else if (m[0]) mag = 1;
      else mag = 0;
      acc = acc * 8 + (v[i][4] ? -mag : mag);
    end
    w   = acc[26:0];
    ws  = w[26] ? longint'(w) - (longint'(1) << 27) : longint'(w);
    mrg = (ws < 0) || (ws >= (longint'(1) << NB));
    my  = w[NB-1:0];
  endfunction

  // Cycle-level reference: one transaction in flight, result due 9 edges after accept.
  int            neg_cnt = 0;
  int            acc_neg = 0;
  bit            busy = 1'b0;
  logic [NB-1:0] exp_y;
  logic          exp_oh;
  logic          exp_rg;

  always @(negedge clk) begin
    bit exp_ov;
    neg_cnt++;
    exp_ov = busy && (neg_cnt >= acc_neg + NP + 1);
    check("mdl_in_ready", in_ready, !busy);
    check("mdl_out_valid", out_valid, exp_ov);
    if (exp_ov && out_valid) begin
      check("mdl_y", y, exp_y);
      check("mdl_err_onehot", err_onehot, exp_oh);
      check("mdl_err_range", err_range, exp_rg);
    end
    if (rst) begin
      busy = 1'b0;
    end else if (!busy && in_valid) begin
      busy    = 1'b1;
      acc_neg = neg_cnt;
      model(d, exp_y, exp_oh, exp_rg);
    end else if (exp_ov && out_ready) begin
      busy = 1'b0;
    end
  end

  task automatic wait_idle(input string tag);
    int w = 0;
    while (!in_ready && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  task automatic do_vec(input vec_t v, input int hold, input logic [NB-1:0] ey,
                        input logic eoh, input logic erg, input string tag);
    int            n;
    logic [NB-1:0] held_y;
    wait_idle(tag);
    d        = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    d         = '1;
    out_ready = (hold == 0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, NP);
    if (out_valid) begin
      held_y = y;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        check({tag, "_hold_valid"}, out_valid, 1);
        check({tag, "_hold_y"}, y, held_y);
      end
      check({tag, "_y"}, y, ey);
      check({tag, "_err_onehot"}, err_onehot, eoh);
      check({tag, "_err_range"}, err_range, erg);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, "_released"}, out_valid, 0);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0x0 expected 0x1");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t          v_zero, v_ff, v_one, v_800, v_bad, v_neg4, v_123;
    logic [NB-1:0] my;
    logic          moh, mrg;

    v_zero = '0;
    v_ff   = '0;
    v_ff[0] = N1;
    for (int i = 1; i < 8; i++) v_ff[i] = NZ;
    v_ff[8] = P1;
    v_one  = '0;
    v_one[0] = P1;
    v_800  = '0;
    v_800[7] = P4;
    v_bad  = '0;
    v_bad[3] = BAD;
    v_neg4 = '0;
    v_neg4[0] = N4;
    v_123  = '0;
    v_123[0] = N2; v_123[1] = P3; v_123[2] = P1; v_123[3] = P2;
    v_123[4] = P3; v_123[5] = P4; v_123[6] = P4;

    model(v_ff, my, moh, mrg);
    check("pin_model_ff_y", my, 24'hFFFFFF);
    check("pin_model_ff_rg", mrg, 0);
    model(v_neg4, my, moh, mrg);
    check("pin_model_neg4_y", my, 24'hFFFFFC);
    check("pin_model_neg4_rg", mrg, 1);
    model(v_123, my, moh, mrg);
    check("pin_model_123_y", my, 24'h123456);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_err_onehot", err_onehot, 0);
    check("rst_err_range", err_range, 0);

    do_vec(v_zero, 0, 24'h000000, 1'b0, 1'b0, "zero");
    do_vec(v_ff,   0, 24'hFFFFFF, 1'b0, 1'b0, "all_ones");
    do_vec(v_one,  0, 24'h000001, 1'b0, 1'b0, "one");
    do_vec(v_800,  5, 24'h800000, 1'b0, 1'b0, "msb_hold");
    do_vec(v_bad,  0, 24'h000000, 1'b1, 1'b0, "onehot");
    do_vec(v_neg4, 0, 24'hFFFFFC, 1'b0, 1'b1, "neg4");

    wait_idle("midrun");
    d        = v_ff;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrun_in_ready", in_ready, 1);
    check("midrun_out_valid", out_valid, 0);
    check("midrun_y", y, 0);
    check("midrun_err_range", err_range, 0);
    repeat (12) @(posedge clk);
    #1;
    check("midrun_no_result", out_valid, 0);

    do_vec(v_123, 0, 24'h123456, 1'b0, 1'b0, "after_rst");
    do_vec(v_one, 0, 24'h000001, 1'b0, 1'b0, "b2b_one");

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
